rv32i_core: RTL and testbench
=============================

# rv32i_core

Single-cycle RV32I integer core: fetches one 32-bit instruction per clock from an external combinational instruction ROM, executes it, and accesses an external word-wide data RAM through a combinational-read/synchronous-write port. Top-level processing element of the SoC, with instruction memory and data memory instantiated beside it. Contains the PC register, 32×32 register file, immediate generator, ALU, branch comparator and main decoder.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock for all state
- RESET  in  1  synchronous, active-high reset
- instruction  in  32  instruction word at PC (combinational ROM output)
- PC  out  32  current program counter, byte address, registered
- read_data  in  32  load data from RAM at alu_result (combinational)
- read_data2  out  32  rs2 register value, used as store data
- MemWrite  out  1  store strobe; RAM writes on the next CLK rising edge
- MemRead  out  1  high for load instructions
- alu_result  out  32  ALU output; data byte address for loads/stores

## Operation
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Any other opcode (incl. LB/LH/SB/SH, FENCE, SYSTEM): executes as NOP (no reg write, MemWrite=0, MemRead=0, PC+4).
- x0 reads as 0; writes to x0 discarded.
- Immediates sign-extended per I/S/B/U/J formats; B/J offsets have bit0=0.
- Shifts use shamt = operand_b[4:0]; SRA/SRAI arithmetic. SLT signed, SLTU unsigned (0/1 result).
- Arithmetic 32-bit, wrap-around modulo 2^32, no overflow flag.
- Writeback source: ALU (R/I/LUI/AUIPC), read_data (LW), PC+4 (JAL/JALR).
- Next PC: PC+4 default; PC+immB if branch taken; PC+immJ for JAL; (rs1+immI) & ~1 for JALR.
- alu_result for LW/SW = rs1 + imm; for branches = comparator operands' difference (don't-care externally).
- Misaligned addresses not trapped; memory truncates address.

## Timing
- Single cycle: all decode/ALU/memory-read combinational within the cycle; PC and register file update on CLK rising edge.
- RESET high at a rising edge: PC ← 0x00000000, all 31 registers ← 0; no writeback, no store in that cycle.
- While RESET high: MemWrite=0, MemRead=0; alu_result and read_data2 remain combinational.
- First instruction after RESET deasserts executes from PC=0.
- Register read-after-write: the value written at an edge is visible to the instruction of the next cycle; no bypassing needed within a cycle.
- Reset mid-program: takes effect at the next edge regardless of instruction; pending store suppressed.

## Configuration
- Macro RV_UPPER_IMM_EN.
- Defined: LUI (rd ← immU) and AUIPC (rd ← PC + immU) implemented.
- Undefined: opcodes 0110111 and 0010111 treated as NOP.

## Test plan
- Reset: RESET=1 one cycle then 0 → PC=0x0, MemWrite=0; after 3 NOPs (ADDI x0,x0,0) PC=0xC.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; SLT x5,x2,x1; SLTU x6,x2,x1 → x3=2, x4=0xFFFFFFF8, x5=1, x6=0 (check via alu_result).
- ADDI x1,x0,0x40; ADDI x2,x0,0x55; SW x2,4(x1) → alu_result=0x44, read_data2=0x55, MemWrite=1 for one cycle; LW x3,4(x1) → MemRead=1, x3=0x55.
- BEQ x1,x1,+8 at PC=0x10 → next PC=0x18; BNE x1,x1,+8 → next PC=0x14; BLT with -1 vs 1 taken, BLTU not taken.
- JAL x1,+0x20 at PC=0x8 → PC=0x28, x1=0xC; JALR x0,0(x1) → PC=0xC.
- ADDI x0,x0,7 then ADD x1,x0,x0 → x1=0; LUI x1,0x12345 → alu_result=0x12345000 (macro defined), NOP behaviour when undefined.

Source files
------------

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute, PC and register file update on CLK.
// Optional LUI/AUIPC support is enabled by defining RV_UPPER_IMM_EN.
module rv32i_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction,
  output logic [31:0] PC,
  input  logic [31:0] read_data,
  output logic [31:0] read_data2,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] alu_result
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef RV_UPPER_IMM_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val, rs2_val, pc_plus4;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
`ifdef RV_UPPER_IMM_EN
  logic [31:0] imm_u;
`endif

  assign opcode   = instruction[6:0];
  assign rd       = instruction[11:7];
  assign funct3   = instruction[14:12];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign funct7_5 = instruction[30];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
`ifdef RV_UPPER_IMM_EN
  assign imm_u = {instruction[31:12], 12'b0};
`endif

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Main decoder: unsupported opcodes/funct3 keep the NOP defaults.
  logic [31:0] op_a, op_b;
  logic [2:0]  alu_f3;
  logic        alu_alt, reg_we, mem_we, mem_re, is_branch, is_jal, is_jalr;
  wb_sel_e     wb_sel;

  always_comb begin
    op_a      = rs1_val;
    op_b      = rs2_val;
    alu_f3    = 3'b000;
    alu_alt   = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    wb_sel    = WB_ALU;
    case (opcode)
      OP_R: begin
        alu_f3  = funct3;
        alu_alt = funct7_5;
        reg_we  = 1'b1;
      end
      OP_IMM: begin
        op_b    = imm_i;
        alu_f3  = funct3;
        alu_alt = (funct3 == 3'b101) && funct7_5;
        reg_we  = 1'b1;
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        op_b   = imm_i;
        reg_we = 1'b1;
        mem_re = 1'b1;
        wb_sel = WB_MEM;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        op_b   = imm_s;
        mem_we = 1'b1;
      end
      OP_BRANCH: begin
        alu_alt   = 1'b1;
        is_branch = 1'b1;
      end
      OP_JAL: begin
        op_a   = pc_q;
        op_b   = imm_j;
        reg_we = 1'b1;
        is_jal = 1'b1;
        wb_sel = WB_PC4;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        op_b    = imm_i;
        reg_we  = 1'b1;
        is_jalr = 1'b1;
        wb_sel  = WB_PC4;
      end
`ifdef RV_UPPER_IMM_EN
      OP_LUI: begin
        op_a   = 32'd0;
        op_b   = imm_u;
        reg_we = 1'b1;
      end
      OP_AUIPC: begin
        op_a   = pc_q;
        op_b   = imm_u;
        reg_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  logic [31:0] alu_out;
  logic [4:0]  shamt;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_out = 32'd0;
    case (alu_f3)
      3'b000: alu_out = alu_alt ? (op_a - op_b) : (op_a + op_b);
      3'b001: alu_out = op_a << shamt;
      3'b010: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011: alu_out = {31'd0, op_a < op_b};
      3'b100: alu_out = op_a ^ op_b;
      3'b101: alu_out = alu_alt ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
      3'b110: alu_out = op_a | op_b;
      3'b111: alu_out = op_a & op_b;
      default: ;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = (rs1_val == rs2_val);
      3'b001: taken = (rs1_val != rs2_val);
      3'b100: taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: taken = (rs1_val <  rs2_val);
      3'b111: taken = (rs1_val >= rs2_val);
      default: ;
    endcase
  end

  logic [31:0] jalr_sum;
  assign jalr_sum = rs1_val + imm_i;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal)                  pc_d = pc_q + imm_j;
    else if (is_jalr)            pc_d = {jalr_sum[31:1], 1'b0};
    else if (is_branch && taken) pc_d = pc_q + imm_b;
  end

  logic [31:0] wb_data;
  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = read_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_out;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (reg_we && (rd != 5'd0)) rf_q[rd] <= wb_data;
    end
  end

  assign PC         = pc_q;
  assign read_data2 = rs2_val;
  assign alu_result = alu_out;
  assign MemWrite   = mem_we & ~RESET;
  assign MemRead    = mem_re & ~RESET;
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: a small ROM/RAM beside the core and hand-computed
// expectations for reset, ALU, load/store, branches, jumps, x0 and upper immediates.
module tb_rv32i_core;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] instruction, PC, read_data, read_data2, alu_result;
  logic        MemWrite, MemRead;
  logic        ram_clr = 1'b1;
  logic [31:0] rom [0:63];
  logic [31:0] ram [0:63];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  rv32i_core dut (
    .CLK(CLK), .RESET(RESET), .instruction(instruction), .PC(PC),
    .read_data(read_data), .read_data2(read_data2), .MemWrite(MemWrite),
    .MemRead(MemRead), .alu_result(alu_result)
  );

  always #5 CLK = ~CLK;

  assign instruction = rom[PC[7:2]];
  assign read_data   = ram[alu_result[7:2]];

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
    end else if (MemWrite) begin
      ram[alu_result[7:2]] <= read_data2;
    end
  end

  // Instruction encoders
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_alu(input string tag, input logic [31:0] exp);
    check(tag, alu_result, exp);
    tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a store sitting at PC 0: strobes must stay low
    clear_rom();
    rom[0] = enc_s(4, 2, 1, 2);
    tick();
    ram_clr = 1'b0;
    check("reset_pc", PC, 32'h0);
    check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
    check("reset_memread", {31'd0, MemRead}, 32'd0);
    rom[0] = NOP;
    RESET = 1'b0;
    #1;
    check("nop_memwrite", {31'd0, MemWrite}, 32'd0);
    tick(); tick(); tick();
    check("pc_after_3_nops", PC, 32'hC);

    // ALU
    clear_rom();
    rom[0]  = enc_i(5, 0, 0, 1, 'h13);
    rom[1]  = enc_i(-3, 0, 0, 2, 'h13);
    rom[2]  = enc_r(0, 2, 1, 0, 3);
    rom[3]  = enc_r('h20, 1, 2, 0, 4);
    rom[4]  = enc_r(0, 1, 2, 2, 5);
    rom[5]  = enc_r(0, 1, 2, 3, 6);
    rom[6]  = enc_i('h0F, 1, 4, 7, 'h13);
    rom[7]  = enc_i('h401, 2, 5, 8, 'h13);
    rom[8]  = enc_i(28, 2, 5, 9, 'h13);
    rom[9]  = enc_i(4, 1, 1, 10, 'h13);
    rom[10] = enc_i(0, 3, 0, 12, 'h13);
    rom[11] = enc_r(0, 6, 5, 0, 13);
    rom[12] = enc_r('h20, 1, 2, 5, 14);
    rom[13] = enc_r(0, 1, 2, 5, 15);
    rom[14] = enc_i(0, 2, 2, 16, 'h13);
    rom[15] = enc_i(-1, 1, 3, 17, 'h13);
    rom[16] = enc_r(0, 2, 1, 6, 18);
    rom[17] = enc_r(0, 2, 1, 7, 19);
    reset_dut();
    exp_alu("addi_5", 32'h5);
    exp_alu("addi_neg3", 32'hFFFF_FFFD);
    exp_alu("add", 32'h2);
    exp_alu("sub", 32'hFFFF_FFF8);
    exp_alu("slt", 32'h1);
    exp_alu("sltu", 32'h0);
    exp_alu("xori", 32'hA);
    exp_alu("srai", 32'hFFFF_FFFE);
    exp_alu("srli", 32'hF);
    exp_alu("slli", 32'h50);
    exp_alu("raw_x3", 32'h2);
    exp_alu("add_x5_x6", 32'h1);
    exp_alu("sra", 32'hFFFF_FFFF);
    exp_alu("srl", 32'h07FF_FFFF);
    exp_alu("slti", 32'h1);
    exp_alu("sltiu_max", 32'h1);
    exp_alu("or", 32'hFFFF_FFFD);
    exp_alu("and", 32'h5);

    // Load/store, with a reset landing on the store first
    clear_rom();
    rom[0] = enc_i('h40, 0, 0, 1, 'h13);
    rom[1] = enc_i('h55, 0, 0, 2, 'h13);
    rom[2] = enc_s(4, 2, 1, 2);
    rom[3] = enc_i(4, 1, 2, 3, 'h03);
    rom[4] = enc_i(0, 3, 0, 4, 'h13);
    reset_dut();
    tick(); tick();
    check("at_sw_pc", PC, 32'h8);
    RESET = 1'b1;
    #1;
    check("mid_reset_memwrite", {31'd0, MemWrite}, 32'd0);
    tick();
    check("mid_reset_pc", PC, 32'h0);
    check("mid_reset_store_dropped", ram[17], 32'h0);
    rom[0] = enc_r(0, 2, 1, 0, 5);
    #1;
    check("regs_cleared", alu_result, 32'h0);
    rom[0] = enc_i('h40, 0, 0, 1, 'h13);
    tick();
    RESET = 1'b0;
    exp_alu("base_addr", 32'h40);
    exp_alu("store_val", 32'h55);
    check("sw_addr", alu_result, 32'h44);
    check("sw_data", read_data2, 32'h55);
    check("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    check("sw_memread", {31'd0, MemRead}, 32'd0);
    tick();
    check("lw_addr", alu_result, 32'h44);
    check("lw_memread", {31'd0, MemRead}, 32'd1);
    check("lw_memwrite", {31'd0, MemWrite}, 32'd0);
    check("ram_written", ram[17], 32'h55);
    tick();
    exp_alu("lw_writeback", 32'h55);

    // Branches
    clear_rom();
    rom[0]  = enc_i(1, 0, 0, 1, 'h13);
    rom[1]  = enc_i(-1, 0, 0, 2, 'h13);
    rom[4]  = enc_b(0, 1, 1, 8);
    rom[6]  = enc_b(1, 1, 1, 8);
    rom[7]  = enc_b(4, 2, 1, 8);
    rom[9]  = enc_b(6, 2, 1, 8);
    rom[10] = enc_b(7, 1, 2, 8);
    rom[11] = enc_b(5, 1, 2, 'h10);
    rom[15] = enc_b(0, 0, 0, -'h14);
    reset_dut();
    tick(); tick(); tick(); tick();
    check("at_beq", PC, 32'h10);
    tick(); check("beq_taken", PC, 32'h18);
    tick(); check("bne_not_taken", PC, 32'h1C);
    tick(); check("blt_taken", PC, 32'h24);
    tick(); check("bltu_not_taken", PC, 32'h28);
    tick(); check("bgeu_not_taken", PC, 32'h2C);
    tick(); check("bge_taken", PC, 32'h3C);
    tick(); check("beq_backward", PC, 32'h28);

    // Jumps
    clear_rom();
    rom[2]  = enc_j(1, 'h20);
    rom[10] = enc_i(0, 1, 0, 0, 'h67);
    rom[3]  = enc_i(0, 1, 0, 5, 'h13);
    rom[4]  = enc_i('h31, 0, 0, 7, 'h13);
    rom[5]  = enc_i(0, 7, 0, 6, 'h67);
    rom[12] = enc_i(0, 6, 0, 8, 'h13);
    reset_dut();
    tick(); tick(); tick();
    check("jal_target", PC, 32'h28);
    check("jalr_sum", alu_result, 32'hC);
    tick();
    check("jalr_target", PC, 32'hC);
    check("jal_link", alu_result, 32'hC);
    tick(); tick(); tick();
    check("jalr_clear_bit0", PC, 32'h30);
    check("jalr_link", alu_result, 32'h18);

    // x0, upper immediates, unsupported opcodes
    clear_rom();
    rom[0] = enc_i(7, 0, 0, 0, 'h13);
    rom[1] = enc_r(0, 0, 0, 0, 1);
    rom[2] = enc_u('h37, 1, 'h12345);
    rom[3] = enc_i(0, 1, 0, 2, 'h13);
    rom[4] = enc_u('h17, 3, 'h1);
    rom[5] = enc_i(0, 3, 0, 4, 'h13);
    rom[6] = enc_s(0, 1, 0, 0);
    rom[7] = enc_i(0, 0, 0, 5, 'h03);
    rom[8] = 32'h0000_000F;
    reset_dut();
    exp_alu("addi_x0", 32'h7);
    exp_alu("x0_reads_zero", 32'h0);
`ifdef RV_UPPER_IMM_EN
    check("lui_alu", alu_result, 32'h1234_5000);
`endif
    check("lui_memwrite", {31'd0, MemWrite}, 32'd0);
    tick();
`ifdef RV_UPPER_IMM_EN
    exp_alu("lui_writeback", 32'h1234_5000);
`else
    exp_alu("lui_is_nop", 32'h0);
`endif
    tick();
`ifdef RV_UPPER_IMM_EN
    exp_alu("auipc_writeback", 32'h1010);
`else
    exp_alu("auipc_is_nop", 32'h0);
`endif
    check("sb_no_store", {31'd0, MemWrite}, 32'd0);
    tick();
    check("lb_no_read", {31'd0, MemRead}, 32'd0);
    tick(); tick();
    check("fence_pc4", PC, 32'h24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
